// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 5;

   // Low address bits of a word-aligned access
   localparam logic [1:0] ALIGN_BITS = 2'b00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ABORT = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts REQ cycles that end without dmem_ready. expired is high during the
// last REQ cycle the stage may spend waiting, so MAX_WAIT REQ cycles in total
// precede an abort.
module mem_wait_timer #(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

   logic [CNT_W-1:0] count;

   // Zero outside REQ, step once per unanswered REQ cycle, hold at the limit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    count <= '0;
      else if (clear)                count <= '0;
      else if (enable && !expired)   count <= count + CNT_W'(1);
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes ALU ops straight to writeback, runs aligned LW/SW
// through a ready-handshake data memory with a timeout, and flags
// misaligned or contradictory accesses as faults.
module mem_stage
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 reg_write,
   input  logic [ADDR_W-1:0]    alu_result,
   input  logic [DATA_W-1:0]    store_data,
   input  logic [REG_IDX_W-1:0] dest_reg,
   output logic                 stall_flag,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [ADDR_W-1:0]    dmem_addr,
   output logic [DATA_W-1:0]    dmem_wdata,
   input  logic                 dmem_ready,
   input  logic [DATA_W-1:0]    dmem_rdata,
   output logic                 wb_valid,
   output logic                 wb_reg_write,
   output logic                 wb_err,
   output logic [REG_IDX_W-1:0] wb_dest,
   output logic [DATA_W-1:0]    wb_data
);

   mem_state_t           state;
   logic                 lat_load;
   logic                 lat_reg_write;
   logic [REG_IDX_W-1:0] lat_dest;
   logic                 wait_expired;

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != REQ),
      .enable  ((state == REQ) && !dmem_ready),
      .expired (wait_expired)
   );

   // Stage FSM; every output is registered so dmem_* stay stable through REQ
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         stall_flag    <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_err        <= 1'b0;
         wb_dest       <= '0;
         wb_data       <= '0;
         lat_load      <= 1'b0;
         lat_reg_write <= 1'b0;
         lat_dest      <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (!mem_read && !mem_write) begin
                     wb_valid     <= 1'b1;
                     wb_err       <= 1'b0;
                     wb_reg_write <= reg_write;
                     wb_dest      <= dest_reg;
                     wb_data      <= alu_result;
                  end else if ((mem_read && mem_write) ||
                               (alu_result[1:0] != ALIGN_BITS)) begin
                     // Faulting access retires at once without touching memory
                     wb_valid     <= 1'b1;
                     wb_err       <= 1'b1;
                     wb_reg_write <= 1'b0;
                     wb_dest      <= dest_reg;
                     wb_data      <= alu_result;
                  end else begin
                     state         <= REQ;
                     stall_flag    <= 1'b1;
                     dmem_req      <= 1'b1;
                     dmem_we       <= mem_write;
                     dmem_addr     <= alu_result;
                     dmem_wdata    <= store_data;
                     lat_load      <= mem_read;
                     lat_reg_write <= reg_write;
                     lat_dest      <= dest_reg;
                  end
               end
            end
            REQ: begin
               // ready beats the timeout when both land on the same edge
               if (dmem_ready) begin
                  state        <= IDLE;
                  stall_flag   <= 1'b0;
                  dmem_req     <= 1'b0;
                  dmem_we      <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_err       <= 1'b0;
                  wb_reg_write <= lat_load && lat_reg_write;
                  wb_dest      <= lat_dest;
                  wb_data      <= lat_load ? dmem_rdata : dmem_addr;
               end else if (wait_expired) begin
                  state    <= ABORT;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end
            end
            ABORT: begin
               state        <= IDLE;
               stall_flag   <= 1'b0;
               wb_valid     <= 1'b1;
               wb_err       <= 1'b1;
               wb_reg_write <= 1'b0;
               wb_dest      <= lat_dest;
               wb_data      <= dmem_addr;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
